// File: rtl/spi_master_byte.sv
// Single-byte SPI mode-0 master: MSB-first, 8-bit full-duplex transfer per start.
// Define SPI_MASTER_STD_MODE0_EN to sample miso on sclk rise (standard slave); default samples late.
module spi_master_byte #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] tx_sh, tx_d;
  logic [7:0] rx_sh, rx_d;
  logic [7:0] rxdata_d;
  logic       mosi_d, done_d;
  logic       tc, accept;

  assign tc = (cnt == DIV_M1);
  // The edge that ends GAP doubles as an IDLE sampling point, so a held start
  // is accepted exactly 18*CLK_DIV edges after the previous acceptance.
  assign accept = start && ((state == IDLE) || ((state == GAP) && tc));

  always_comb begin
    state_d  = state;
    cnt_d    = tc ? '0 : cnt + 8'd1;
    bit_d    = bit_cnt;
    tx_d     = tx_sh;
    rx_d     = rx_sh;
    rxdata_d = rx_data;
    mosi_d   = mosi;
    done_d   = 1'b0;
    case (state)
      IDLE: cnt_d = '0;
      SETUP: begin
        if (tc) begin
          state_d = HIGH;
`ifdef SPI_MASTER_STD_MODE0_EN
          rx_d = {rx_sh[6:0], miso};
`endif
        end
      end
      HIGH: begin
        if (tc) begin
          state_d = LOW;
          mosi_d  = tx_sh[7];
          tx_d    = {tx_sh[6:0], 1'b0};
`ifdef SPI_MASTER_STD_MODE0_EN
          if (bit_cnt == 3'd7) begin
            done_d   = 1'b1;
            rxdata_d = rx_sh;
          end
`endif
        end
      end
      LOW: begin
        if (tc) begin
          bit_d = bit_cnt + 3'd1;
`ifdef SPI_MASTER_STD_MODE0_EN
          if (bit_cnt == 3'd7) begin
            state_d = GAP;
          end else begin
            rx_d    = {rx_sh[6:0], miso};
            state_d = HIGH;
          end
`else
          rx_d = {rx_sh[6:0], miso};
          if (bit_cnt == 3'd7) begin
            done_d   = 1'b1;
            rxdata_d = {rx_sh[6:0], miso};
            state_d  = GAP;
          end else begin
            state_d = HIGH;
          end
`endif
        end
      end
      GAP: begin
        if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SETUP;
      cnt_d   = '0;
      bit_d   = '0;
      tx_d    = {tx_data[6:0], 1'b0};
      mosi_d  = tx_data[7];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_cnt <= bit_d;
      tx_sh   <= tx_d;
      rx_sh   <= rx_d;
      rx_data <= rxdata_d;
      mosi    <= mosi_d;
      done    <= done_d;
      sclk    <= (state_d == HIGH);
      cs      <= !((state_d == SETUP) || (state_d == HIGH) || (state_d == LOW));
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Bench for spi_master_byte: two instances (CLK_DIV=2 or 3, and CLK_DIV=1) against slave models.
// Build with SPI_MASTER_STD_MODE0_EN to exercise the standard mode-0 sampling variant.
module tb_spi_master_byte;

`ifdef SPI_MASTER_STD_MODE0_EN
  localparam int DA       = 3;
  localparam int DONE_MUL = 16;
`else
  localparam int DA       = 2;
  localparam int DONE_MUL = 17;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a = 1'b0;
  logic [7:0] tx_a = '0, rx_a;
  logic       start_b = 1'b0, busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b = 1'b1;
  logic [7:0] tx_b = '0, rx_b;

  int total = 0;
  int bad   = 0;

  spi_master_byte #(.CLK_DIV(DA)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .tx_data(tx_a), .busy(busy_a),
    .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master_byte #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .tx_data(tx_b), .busy(busy_b),
    .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
  );

  // Slave model on instance A: reacts half a clk after each pin transition.
  logic [7:0] slv_din = '0, slv_sh = '0, slv_rx = '0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (prev_cs && !cs_a) begin
`ifdef SPI_MASTER_STD_MODE0_EN
      miso_a <= slv_din[7];
      slv_sh <= {slv_din[6:0], 1'b0};
`else
      miso_a <= 1'b0;
      slv_sh <= slv_din;
`endif
    end else if (!cs_a && prev_sclk && !sclk_a) begin
      miso_a <= slv_sh[7];
      slv_sh <= {slv_sh[6:0], 1'b0};
    end
    if (!prev_sclk && sclk_a) slv_rx <= {slv_rx[6:0], mosi_a};
    prev_cs   <= cs_a;
    prev_sclk <= sclk_a;
  end

  task automatic frame_a(input logic [7:0] tx, input logic [7:0] din, input int p1,
                         input int p2, input string nm);
    int   rise_c[$];
    logic rise_m[$];
    int   done_c[$];
    int   busy_fall = -1;
    int   cs_err = 0;
    logic [7:0] rx_at = '0;
    logic ps;
    @(negedge clk);
    tx_a = tx; slv_din = din; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; tx_a = ~tx;
    total++;
    if (cs_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL %s accept: cs=%b busy=%b, want cs=0 busy=1", nm, cs_a, busy_a);
    end
    ps = sclk_a;
    for (int c = 1; c <= 18 * DA + 2; c++) begin
      start_a = (c == p1 || c == p2);
      @(posedge clk); #1;
      start_a = 1'b0;
      if (sclk_a && !ps) begin rise_c.push_back(c); rise_m.push_back(mosi_a); end
      ps = sclk_a;
      if (done_a) begin done_c.push_back(c); rx_at = rx_a; end
      if (busy_fall < 0 && !busy_a) busy_fall = c;
      if (cs_a !== (c >= 17 * DA)) cs_err++;
    end
    total++;
    if (rise_c.size() != 8) begin
      bad++; $display("FAIL %s rise_count: got %0d, want 8", nm, rise_c.size());
    end
    for (int k = 0; k < rise_c.size() && k < 8; k++) begin
      total++;
      if (rise_c[k] != DA + 2 * DA * k || rise_m[k] !== tx[7-k]) begin
        bad++;
        $display("FAIL %s rise%0d: got cycle %0d mosi %b, want cycle %0d mosi %b",
                 nm, k, rise_c[k], rise_m[k], DA + 2 * DA * k, tx[7-k]);
      end
    end
    total++;
    if (done_c.size() != 1 || done_c[0] != DONE_MUL * DA) begin
      bad++;
      $display("FAIL %s done: got %0d pulses first at %0d, want 1 pulse at %0d", nm,
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, DONE_MUL * DA);
    end
    total++;
    if (rx_at !== din) begin
      bad++; $display("FAIL %s rx_data: got %h, want %h", nm, rx_at, din);
    end
    total++;
    if (rx_a !== din) begin
      bad++; $display("FAIL %s rx_hold: got %h, want %h", nm, rx_a, din);
    end
    total++;
    if (busy_fall != 18 * DA) begin
      bad++; $display("FAIL %s busy_fall: got %0d, want %0d", nm, busy_fall, 18 * DA);
    end
    total++;
    if (cs_err != 0) begin
      bad++; $display("FAIL %s cs_window: got %0d wrong cycles, want 0", nm, cs_err);
    end
    total++;
    if (slv_rx !== tx) begin
      bad++; $display("FAIL %s slave_rx: got %h, want %h", nm, slv_rx, tx);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sclk_a, cs_a, mosi_a, busy_a, done_a, rx_a} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_a: sclk=%b cs=%b mosi=%b busy=%b done=%b rx=%h, want 0 1 0 0 0 00",
               sclk_a, cs_a, mosi_a, busy_a, done_a, rx_a);
    end
    total++;
    if ({sclk_b, cs_b, mosi_b, busy_b, done_b, rx_b} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_b: sclk=%b cs=%b mosi=%b busy=%b done=%b rx=%h, want 0 1 0 0 0 00",
               sclk_b, cs_b, mosi_b, busy_b, done_b, rx_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    frame_a(8'hA5, (DA == 3) ? 8'hC3 : 8'h3C, -1, -1, "basic");
  endtask

  task automatic test_back_to_back();
    int   acc[$];
    int   dn[$];
    logic mq[$];
    int   gap = 0;
    logic pc, ps;
    @(negedge clk);
    start_b = 1'b1; tx_b = 8'hFF;
    pc = cs_b; ps = sclk_b;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) tx_b = 8'h00;
      if (c == 18) start_b = 1'b0;
      if (!cs_b && pc) acc.push_back(c);
      if (sclk_b && !ps) mq.push_back(mosi_b);
      if (done_b) dn.push_back(c);
      if (cs_b && acc.size() == 1) gap++;
      pc = cs_b; ps = sclk_b;
    end
    total++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != 18) begin
      bad++;
      $display("FAIL b2b_accept: got %0d frames first %0d second %0d, want 2 at 0 and 18",
               acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1);
    end
    total++;
    if (dn.size() != 2 || dn[0] != DONE_MUL || dn[1] != 18 + DONE_MUL) begin
      bad++;
      $display("FAIL b2b_done: got %0d pulses, want 2 at %0d and %0d",
               dn.size(), DONE_MUL, 18 + DONE_MUL);
    end
    total++;
    if (gap < 1) begin
      bad++; $display("FAIL b2b_cs_gap: got %0d cycles, want >=1", gap);
    end
    total++;
    if (mq.size() != 16) begin
      bad++; $display("FAIL b2b_mosi_count: got %0d, want 16", mq.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        total++;
        if (mq[k] !== (k < 8)) begin
          bad++; $display("FAIL b2b_mosi%0d: got %b, want %b", k, mq[k], (k < 8));
        end
      end
    end
    total++;
    if (rx_b !== 8'hFF) begin
      bad++; $display("FAIL b2b_rx: got %h, want ff", rx_b);
    end
  endtask

  task automatic test_ignored_start();
    frame_a(8'($urandom), 8'($urandom), 5, 20, "ignored_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      frame_a(8'($urandom), 8'($urandom), -1, -1, "random");
    end
  endtask

  task automatic test_mid_reset();
    int ndone = 0;
    @(negedge clk);
    tx_a = 8'h77; slv_din = 8'h99; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({cs_a, sclk_a, done_a, busy_a, rx_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL mid_reset: cs=%b sclk=%b done=%b busy=%b rx=%h, want 1 0 0 0 00",
               cs_a, sclk_a, done_a, busy_a, rx_a);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    total++;
    if (ndone != 0 || rx_a !== 8'h00) begin
      bad++; $display("FAIL mid_reset_abort: got %0d done rx=%h, want 0 done rx=00", ndone, rx_a);
    end
    frame_a(8'h5A, 8'h5A, -1, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_start();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
